// File: rtl/maxnet_input_loader.sv
// maxnet_input_loader: gathers four sanitized fp32 activations from a valid/ready stream,
// presents them with epsilon to the Maxnet controller and waits for its done.
module maxnet_input_loader #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] EPS_RST = 32'h3E000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              eps_we,
    input  logic [DATA_W-1:0] eps_in,
    output logic              start,
    input  logic              done,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic [DATA_W-1:0] num3,
    output logic [DATA_W-1:0] num4,
    output logic [DATA_W-1:0] epsilon,
    output logic              clamped,
    output logic              invalid,
    output logic [7:0]        batch_cnt
);
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT} state_t;

    state_t            state, next_state;
    logic [1:0]        word_idx;
    logic              xfer, last, special, clamp_w;
    logic [DATA_W-1:0] san;

    assign in_ready = state == LOAD;
    assign start    = state == ISSUE;
    assign xfer     = in_valid && in_ready;
    assign last     = xfer && word_idx == 2'd3;

    // NaN/Inf and every negative value (including -0) are stored as +0
    assign special = in_data[30:23] == 8'hFF;
    assign clamp_w = !special && in_data[31] && |in_data[30:0];
    assign san     = (special || in_data[31]) ? '0 : in_data;

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    next_state = last ? ISSUE : LOAD;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = done ? LOAD : WAIT;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            word_idx  <= 2'd0;
            num1      <= '0;
            num2      <= '0;
            num3      <= '0;
            num4      <= '0;
            epsilon   <= EPS_RST;
            clamped   <= 1'b0;
            invalid   <= 1'b0;
            batch_cnt <= 8'd0;
        end else begin
            state <= next_state;
            if (xfer) begin
                word_idx <= word_idx + 2'd1;
                case (word_idx)
                    2'd0:    num1 <= san;
                    2'd1:    num2 <= san;
                    2'd2:    num3 <= san;
                    default: num4 <= san;
                endcase
                // flags restart with each batch's first word
                clamped <= (word_idx != 2'd0 && clamped) || clamp_w;
                invalid <= (word_idx != 2'd0 && invalid) || special;
            end
            if (eps_we && state == LOAD)
                epsilon <= {1'b0, eps_in[DATA_W-2:0]};
            if (state == WAIT && done)
                batch_cnt <= batch_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_maxnet_input_loader.sv
// tb_maxnet_input_loader: table vectors, hand sequences and random batches checked against
// a batch-level model of the loader.
module tb_maxnet_input_loader;
    logic        clk = 0, rst = 0, in_valid = 0, in_ready, eps_we = 0, start, done = 0;
    logic [31:0] in_data = 0, eps_in = 0, num1, num2, num3, num4, epsilon;
    logic        clamped, invalid;
    logic [7:0]  batch_cnt;

    maxnet_input_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .eps_we(eps_we), .eps_in(eps_in), .start(start), .done(done),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4), .epsilon(epsilon),
        .clamped(clamped), .invalid(invalid), .batch_cnt(batch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][31:0] w;
        logic [3:0][31:0] e;
        logic             c;
        logic             v;
        int               gap;
    } vec_t;

    int          checks = 0, errors = 0, m_cnt = 0;
    logic [31:0] m_eps = 32'h3E000000;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rules, stated per word class
    function automatic bit is_nan_inf(input logic [31:0] w);
        return w[30:23] == 8'd255;
    endfunction
    function automatic bit is_neg_nonzero(input logic [31:0] w);
        return !is_nan_inf(w) && w[31] && w[30:0] != 0;
    endfunction
    function automatic logic [31:0] model_san(input logic [31:0] w);
        return (is_nan_inf(w) || w[31]) ? 32'h0 : w;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, b, c, d, ea, eb, ec, ed,
                                input logic cl, iv, input int gap);
        vec_t r;
        r.w[0] = a;  r.w[1] = b;  r.w[2] = c;  r.w[3] = d;
        r.e[0] = ea; r.e[1] = eb; r.e[2] = ec; r.e[3] = ed;
        r.c = cl; r.v = iv; r.gap = gap;
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: return {r[31], 8'hFF, r[22:0]};
            1: return 32'h80000000;
            2: return {1'b1, 8'($urandom_range(0, 254)), r[22:0]};
            3: return 32'h0;
            default: return {1'b0, 8'($urandom_range(0, 254)), r[22:0]};
        endcase
    endfunction

    task automatic send_word(input logic [31:0] w, input bit we, input logic [31:0] ev);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready before word", {31'b0, in_ready}, 32'd1);
        in_valid = 1; in_data = w; eps_we = we; eps_in = ev;
        @(negedge clk);
        in_valid = 0; eps_we = 0;
        if (we) m_eps = {1'b0, ev[30:0]};
    endtask

    task automatic pulse_done();
        done = 1;
        @(negedge clk);
        done = 0;
    endtask

    task automatic run_batch(input logic [3:0][31:0] w, input int gap_max, input bit eps_last,
                             input logic [31:0] ev, input int done_delay);
        bit c = 0, v = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], eps_last && i == 3, ev);
            c |= is_neg_nonzero(w[i]);
            v |= is_nan_inf(w[i]);
            if (i == 0) begin
                chk("clamped first word", {31'b0, clamped}, {31'b0, c});
                chk("invalid first word", {31'b0, invalid}, {31'b0, v});
            end
            if (i < 3) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        chk("start in issue", {31'b0, start}, 32'd1);
        chk("in_ready in issue", {31'b0, in_ready}, 32'd0);
        chk("num1", num1, model_san(w[0]));
        chk("num2", num2, model_san(w[1]));
        chk("num3", num3, model_san(w[2]));
        chk("num4", num4, model_san(w[3]));
        chk("clamped", {31'b0, clamped}, {31'b0, c});
        chk("invalid", {31'b0, invalid}, {31'b0, v});
        chk("epsilon", epsilon, m_eps);
        @(negedge clk);
        for (int i = 0; i <= done_delay; i++) begin
            chk("start low in wait", {31'b0, start}, 32'd0);
            chk("in_ready low in wait", {31'b0, in_ready}, 32'd0);
            if (i < done_delay) @(negedge clk);
        end
        pulse_done();
        m_cnt = (m_cnt + 1) % 256;
        chk("in_ready after done", {31'b0, in_ready}, 32'd1);
        chk("batch_cnt", {24'b0, batch_cnt}, m_cnt);
    endtask

    initial begin
        tbl[0] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 0);
        tbl[1] = mk(32'hBF800000, 32'h7FC00000, 32'h80000000, 32'h3F000000,
                    32'h0, 32'h0, 32'h0, 32'h3F000000, 1, 1, 2);
        tbl[2] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 2);
        tbl[3] = mk(32'hFF800000, 32'h80000001, 32'h00800000, 32'h7F7FFFFF,
                    32'h0, 32'h0, 32'h00800000, 32'h7F7FFFFF, 1, 1, 1);
        tbl[4] = mk(32'h7F800000, 32'h00000000, 32'h80000000, 32'h3E000000,
                    32'h0, 32'h0, 32'h0, 32'h3E000000, 0, 1, 0);
        tbl[5] = mk(32'h80000000, 32'h12345678, 32'hFF7FFFFF, 32'h00000001,
                    32'h0, 32'h12345678, 32'h0, 32'h00000001, 1, 0, 3);

        repeat (2) @(negedge clk);
        chk("reset num1", num1, 0);
        chk("reset num4", num4, 0);
        chk("reset epsilon", epsilon, 32'h3E000000);
        chk("reset start", {31'b0, start}, 0);
        chk("reset flags", {30'b0, clamped, invalid}, 0);
        chk("reset batch_cnt", {24'b0, batch_cnt}, 0);
        chk("reset in_ready", {31'b0, in_ready}, 1);
        rst = 1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_batch(tbl[i].w, tbl[i].gap, i == 3, 32'hBE4CCCCD, i);
            chk($sformatf("tbl%0d num1", i), num1, tbl[i].e[0]);
            chk($sformatf("tbl%0d num2", i), num2, tbl[i].e[1]);
            chk($sformatf("tbl%0d num3", i), num3, tbl[i].e[2]);
            chk($sformatf("tbl%0d num4", i), num4, tbl[i].e[3]);
            chk($sformatf("tbl%0d flags", i), {30'b0, clamped, invalid}, {30'b0, tbl[i].c, tbl[i].v});
        end
        chk("eps on 4th word", epsilon, 32'h3E4CCCCD);

        // Standalone epsilon write in LOAD
        eps_we = 1; eps_in = 32'hBE000001;
        @(negedge clk);
        eps_we = 0;
        chk("eps write in load", epsilon, 32'h3E000001);
        m_eps = 32'h3E000001;

        // done during LOAD is ignored
        pulse_done();
        chk("done in load cnt", {24'b0, batch_cnt}, m_cnt);
        chk("done in load ready", {31'b0, in_ready}, 1);

        // done in ISSUE ignored; eps write in WAIT ignored
        for (int i = 0; i < 4; i++) send_word(32'h3F800000 + i, 0, 0);
        chk("start pulse", {31'b0, start}, 1);
        pulse_done();
        chk("stays in wait", {31'b0, in_ready}, 0);
        eps_we = 1; eps_in = 32'hBE4CCCCD;
        @(negedge clk);
        eps_we = 0;
        repeat (2) @(negedge clk);
        chk("still wait", {31'b0, in_ready}, 0);
        chk("no second start", {31'b0, start}, 0);
        chk("eps write in wait", epsilon, m_eps);
        chk("cnt before done", {24'b0, batch_cnt}, m_cnt);
        pulse_done();
        m_cnt = (m_cnt + 1) % 256;
        chk("late done ready", {31'b0, in_ready}, 1);
        chk("late done cnt", {24'b0, batch_cnt}, m_cnt);

        // Reset mid-batch
        send_word(32'h3F800000, 0, 0);
        @(negedge clk);
        send_word(32'h40000000, 0, 0);
        rst = 0;
        #1;
        chk("mid rst num1", num1, 0);
        chk("mid rst num2", num2, 0);
        chk("mid rst eps", epsilon, 32'h3E000000);
        chk("mid rst cnt", {24'b0, batch_cnt}, 0);
        @(negedge clk);
        rst = 1;
        m_cnt = 0;
        m_eps = 32'h3E000000;
        @(negedge clk);

        // Random batches until the counter wraps
        for (int b = 0; b < 256; b++) begin
            logic [3:0][31:0] w;
            for (int i = 0; i < 4; i++) w[i] = rand_word();
            run_batch(w, 2, 0, 0, $urandom_range(0, 3));
        end
        chk("batch_cnt wrap", {24'b0, batch_cnt}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
